// File: rtl/vga_timing_engine.sv
// Runtime-reconfigurable VGA timing engine with pixel enable and framed config apply.
// Optional frame counter: define VGA_TIMING_ENGINE_FRAME_CNT_EN.
module vga_timing_engine #(
    parameter int   CNT_W  = 12,
    parameter int   H_VIS  = 800,
    parameter int   H_FP   = 40,
    parameter int   H_SYNC = 128,
    parameter int   H_BP   = 88,
    parameter int   V_VIS  = 600,
    parameter int   V_FP   = 1,
    parameter int   V_SYNC = 4,
    parameter int   V_BP   = 23,
    parameter logic H_POL  = 1'b1,
    parameter logic V_POL  = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [4*CNT_W-1:0] cfg_h,
    input  logic [4*CNT_W-1:0] cfg_v,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   h_pxl_count,
    output logic [CNT_W-1:0]   v_pxl_count,
    output logic               h_sync,
    output logic               v_sync,
    output logic               h_visible,
    output logic               v_visible,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count
);

    localparam int CW = 4 * CNT_W;
    localparam int TW = CNT_W + 1;
    localparam int LW = CNT_W + 3;
    localparam logic [LW-1:0] MAX_TOT = LW'(2 ** CNT_W);

    localparam logic [CW-1:0] H_DEF = {
        CNT_W'(H_VIS), CNT_W'(H_FP), CNT_W'(H_SYNC), CNT_W'(H_BP)
    };
    localparam logic [CW-1:0] V_DEF = {
        CNT_W'(V_VIS), CNT_W'(V_FP), CNT_W'(V_SYNC), CNT_W'(V_BP)
    };

    function automatic logic [CNT_W-1:0] f_vis(input logic [CW-1:0] c);
        return c[4*CNT_W-1 -: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] f_fp(input logic [CW-1:0] c);
        return c[3*CNT_W-1 -: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] f_sync(input logic [CW-1:0] c);
        return c[2*CNT_W-1 -: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] f_bp(input logic [CW-1:0] c);
        return c[CNT_W-1:0];
    endfunction

    function automatic logic [TW-1:0] total(input logic [CW-1:0] c);
        return TW'(f_vis(c)) + TW'(f_fp(c)) + TW'(f_sync(c)) + TW'(f_bp(c));
    endfunction

    // Wider sum so four maximal fields cannot wrap past the legality limit.
    function automatic logic cfg_ok(input logic [CW-1:0] c);
        logic [LW-1:0] s;
        s = LW'(f_vis(c)) + LW'(f_fp(c)) + LW'(f_sync(c)) + LW'(f_bp(c));
        return (f_vis(c) != '0) && (f_sync(c) != '0) && (s <= MAX_TOT);
    endfunction

    function automatic logic in_sync(
        input logic [CNT_W-1:0] cnt,
        input logic [CW-1:0]    c
    );
        logic [TW-1:0] s;
        logic [TW-1:0] e;
        s = TW'(f_vis(c)) + TW'(f_fp(c));
        e = s + TW'(f_sync(c));
        return ({1'b0, cnt} >= s) && ({1'b0, cnt} < e);
    endfunction

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CW-1:0]    act_h_q, act_h_d, act_v_q, act_v_d;
    logic [CW-1:0]    pend_h_q, pend_h_d, pend_v_q, pend_v_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_err_q, cfg_err_d;
    logic             h_sync_q, h_sync_d, v_sync_q, v_sync_d;
    logic             h_vis_q, h_vis_d, v_vis_q, v_vis_d;
    logic             ls_q, ls_d, fs_q, fs_d;
    logic [TW-1:0]    h_tot, v_tot;
    logic             h_last, v_last, wrap, xfer, apply, ok;

    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        act_h_d     = act_h_q;
        act_v_d     = act_v_q;
        pend_h_d    = pend_h_q;
        pend_v_d    = pend_v_q;
        cfg_ready_d = cfg_ready_q;

        h_tot  = total(act_h_q);
        v_tot  = total(act_v_q);
        h_last = ({1'b0, h_q} == h_tot - 1'b1);
        v_last = ({1'b0, v_q} == v_tot - 1'b1);
        wrap   = pix_en && h_last && v_last;
        xfer   = cfg_valid && cfg_ready_q;
        ok     = cfg_ok(cfg_h) && cfg_ok(cfg_v);
        // A full slot is exactly a deasserted ready.
        apply  = wrap && !cfg_ready_q;

        if (pix_en) begin
            h_d = h_last ? '0 : h_q + 1'b1;
            if (h_last) begin
                v_d = v_last ? '0 : v_q + 1'b1;
            end
        end

        if (apply) begin
            act_h_d     = pend_h_q;
            act_v_d     = pend_v_q;
            cfg_ready_d = 1'b1;
        end

        if (xfer && ok) begin
            pend_h_d    = cfg_h;
            pend_v_d    = cfg_v;
            cfg_ready_d = 1'b0;
        end

        cfg_err_d = xfer && !ok;
        h_sync_d  = in_sync(h_d, act_h_d) ? H_POL : ~H_POL;
        v_sync_d  = in_sync(v_d, act_v_d) ? V_POL : ~V_POL;
        h_vis_d   = h_d < f_vis(act_h_d);
        v_vis_d   = v_d < f_vis(act_v_d);
        ls_d      = pix_en && (h_d == '0);
        fs_d      = ls_d && (v_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_q         <= '0;
            v_q         <= '0;
            act_h_q     <= H_DEF;
            act_v_q     <= V_DEF;
            pend_h_q    <= '0;
            pend_v_q    <= '0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            h_sync_q    <= ~H_POL;
            v_sync_q    <= ~V_POL;
            h_vis_q     <= 1'b1;
            v_vis_q     <= 1'b1;
            ls_q        <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            act_h_q     <= act_h_d;
            act_v_q     <= act_v_d;
            pend_h_q    <= pend_h_d;
            pend_v_q    <= pend_v_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
            h_vis_q     <= h_vis_d;
            v_vis_q     <= v_vis_d;
            ls_q        <= ls_d;
            fs_q        <= fs_d;
        end
    end

`ifdef VGA_TIMING_ENGINE_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if (wrap) begin
            fc_d = apply ? 16'd0 : fc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fc_q <= 16'd0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frame_count = fc_q;
`else
    assign frame_count = 16'd0;
`endif

    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;
    assign h_pxl_count = h_q;
    assign v_pxl_count = v_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign h_visible   = h_vis_q;
    assign v_visible   = v_vis_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench for vga_timing_engine on a shrunken 16x8 default raster.
// A cycle model tracks counts/config; hand values pin the key boundaries.
module tb_vga_timing_engine;

    localparam int W = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pix_en = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [4*W-1:0] cfg_h = '0;
    logic [4*W-1:0] cfg_v = '0;
    logic          cfg_ready, cfg_err;
    logic [W-1:0]  h_pxl_count, v_pxl_count;
    logic          h_sync, v_sync, h_visible, v_visible;
    logic          line_start, frame_start;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    vga_timing_engine #(
        .CNT_W(W),
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pix_en(pix_en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_h(cfg_h),
        .cfg_v(cfg_v),
        .cfg_err(cfg_err),
        .h_pxl_count(h_pxl_count),
        .v_pxl_count(v_pxl_count),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .h_visible(h_visible),
        .v_visible(v_visible),
        .line_start(line_start),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    localparam logic [4*W-1:0] DEF_H = {12'd8, 12'd2, 12'd3, 12'd3};
    localparam logic [4*W-1:0] DEF_V = {12'd4, 12'd1, 12'd2, 12'd1};
    localparam logic [4*W-1:0] NEW_H = {12'd6, 12'd1, 12'd2, 12'd1};
    localparam logic [4*W-1:0] NEW_V = {12'd3, 12'd1, 12'd1, 12'd1};

    int checks = 0;
    int failures = 0;
    int n_fs = 0;

    int mh, mv, mfc;
    logic [4*W-1:0] m_act_h, m_act_v, m_pend_h, m_pend_v;
    logic m_pend, m_ready, m_err, m_ls, m_fs;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fld(input logic [4*W-1:0] c, input int i);
        return int'((c >> (i * W)) & 48'hFFF);
    endfunction

    function automatic int tot(input logic [4*W-1:0] c);
        return fld(c, 3) + fld(c, 2) + fld(c, 1) + fld(c, 0);
    endfunction

    function automatic bit legal(input logic [4*W-1:0] c);
        return fld(c, 3) != 0 && fld(c, 1) != 0 && tot(c) <= 4096;
    endfunction

    function automatic bit sync_on(input int n, input logic [4*W-1:0] c);
        int s;
        s = fld(c, 3) + fld(c, 2);
        return n >= s && n < s + fld(c, 1);
    endfunction

    task automatic model_step();
        int  ht, vt;
        bit  xfer, ok, wrap;
        if (!reset_n) begin
            mh = 0; mv = 0; mfc = 0;
            m_act_h = DEF_H; m_act_v = DEF_V;
            m_pend = 0; m_ready = 1; m_err = 0; m_ls = 0; m_fs = 0;
            return;
        end
        ht = tot(m_act_h);
        vt = tot(m_act_v);
        xfer = cfg_valid && m_ready;
        ok = legal(cfg_h) && legal(cfg_v);
        wrap = pix_en && mh == ht - 1 && mv == vt - 1;
        m_err = xfer && !ok;
        if (pix_en) begin
            if (mh == ht - 1) begin
                mh = 0;
                mv = (mv == vt - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        m_ls = pix_en && mh == 0;
        m_fs = m_ls && mv == 0;
        if (wrap) mfc = (mfc + 1) % 65536;
        if (wrap && m_pend) begin
            m_act_h = m_pend_h; m_act_v = m_pend_v;
            m_pend = 0; m_ready = 1; mfc = 0;
        end
        if (xfer && ok) begin
            m_pend_h = cfg_h; m_pend_v = cfg_v;
            m_pend = 1; m_ready = 0;
        end
    endtask

    task automatic check_all();
        chk("h_count", 32'(h_pxl_count), 32'(mh));
        chk("v_count", 32'(v_pxl_count), 32'(mv));
        chk("h_sync", 32'(h_sync), sync_on(mh, m_act_h) ? 1 : 0);
        chk("v_sync", 32'(v_sync), sync_on(mv, m_act_v) ? 0 : 1);
        chk("h_visible", 32'(h_visible), 32'(mh < fld(m_act_h, 3)));
        chk("v_visible", 32'(v_visible), 32'(mv < fld(m_act_v, 3)));
        chk("line_start", 32'(line_start), 32'(m_ls));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef VGA_TIMING_ENGINE_FRAME_CNT_EN
        chk("frame_count", 32'(frame_count), 32'(mfc));
`else
        chk("frame_count", 32'(frame_count), 0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (frame_start === 1'b1) n_fs++;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int th, input int tv);
        int k;
        k = 0;
        while (!(mh == th && mv == tv) && k < 400) begin
            tick();
            k++;
        end
        chk("run_to_timeout", 32'(k < 400), 1);
    endtask

    task automatic offer(input logic [4*W-1:0] h, input logic [4*W-1:0] v);
        cfg_h = h;
        cfg_v = v;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_h", 32'(h_pxl_count), 0);
        chk("rst_v", 32'(v_pxl_count), 0);
        chk("rst_hsync", 32'(h_sync), 0);
        chk("rst_vsync", 32'(v_sync), 1);
        chk("rst_hvis", 32'(h_visible), 1);
        chk("rst_vvis", 32'(v_visible), 1);
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_fc", 32'(frame_count), 0);

        reset_n = 1'b1;
        pix_en = 1'b1;
        ticks(10);
        chk("h10", 32'(h_pxl_count), 10);
        chk("h10_sync", 32'(h_sync), 1);
        chk("h10_vis", 32'(h_visible), 0);
        ticks(246);
        chk("two_frames_fs", 32'(n_fs), 2);
        chk("two_frames_h", 32'(h_pxl_count), 0);
        chk("two_frames_v", 32'(v_pxl_count), 0);

        pix_en = 1'b0;
        tick();
        chk("hold_h", 32'(h_pxl_count), 0);
        chk("hold_ls", 32'(line_start), 0);
        chk("hold_fs", 32'(frame_start), 0);
        tick();
        pix_en = 1'b1;
        tick();
        chk("resume_h", 32'(h_pxl_count), 1);

        run_to(0, 3);
        offer(NEW_H, NEW_V);
        chk("mid_ready0", 32'(cfg_ready), 0);
        run_to(15, 7);
        chk("pre_apply_ready", 32'(cfg_ready), 0);
        tick();
        chk("apply_h", 32'(h_pxl_count), 0);
        chk("apply_v", 32'(v_pxl_count), 0);
        chk("apply_ready", 32'(cfg_ready), 1);
        ticks(7);
        chk("new_h7_sync", 32'(h_sync), 1);
        ticks(2);
        chk("new_h9_sync", 32'(h_sync), 0);
        tick();
        chk("new_hwrap_h", 32'(h_pxl_count), 0);
        chk("new_hwrap_v", 32'(v_pxl_count), 1);
        run_to(9, 5);
        tick();
        chk("new_vwrap_v", 32'(v_pxl_count), 0);

        offer({12'd0, 12'd1, 12'd2, 12'd1}, NEW_V);
        chk("vis0_err", 32'(cfg_err), 1);
        chk("vis0_ready", 32'(cfg_ready), 1);
        tick();
        chk("vis0_err_clr", 32'(cfg_err), 0);
        offer(NEW_H, {12'd4000, 12'd50, 12'd40, 12'd7});
        chk("tot4097_err", 32'(cfg_err), 1);
        chk("tot4097_ready", 32'(cfg_ready), 1);
        offer(NEW_H, {12'd3, 12'd1, 12'd0, 12'd1});
        chk("sync0_err", 32'(cfg_err), 1);
        run_to(9, 5);
        tick();
        chk("illegal_keep_v", 32'(v_pxl_count), 0);

        run_to(9, 5);
        offer(DEF_H, DEF_V);
        chk("cowrap_h", 32'(h_pxl_count), 0);
        chk("cowrap_ready", 32'(cfg_ready), 0);
        ticks(10);
        chk("cowrap_old_h", 32'(h_pxl_count), 0);
        chk("cowrap_old_v", 32'(v_pxl_count), 1);
        run_to(9, 5);
        tick();
        ticks(10);
        chk("cowrap_new_h", 32'(h_pxl_count), 10);
        chk("cowrap_new_sync", 32'(h_sync), 1);

        run_to(0, 2);
        offer(NEW_H, NEW_V);
        chk("pend_ready", 32'(cfg_ready), 0);
        ticks(5);
        reset_n = 1'b0;
        tick();
        chk("mrst_h", 32'(h_pxl_count), 0);
        chk("mrst_v", 32'(v_pxl_count), 0);
        chk("mrst_ready", 32'(cfg_ready), 1);
        chk("mrst_vsync", 32'(v_sync), 1);
        chk("mrst_fc", 32'(frame_count), 0);
        reset_n = 1'b1;
        ticks(16);
        chk("mrst_def_v", 32'(v_pxl_count), 1);
        ticks(112);
        chk("mrst_def_wrap", 32'(v_pxl_count), 0);
        ticks(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
